// File: rtl/composite_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : composite_timing_gen
// Purpose  : Composite-video line/field timing and DAC level generator.
//            Serrated vertical sync, optional 262/263-line interlaced fields,
//            and a fixed two-cycle pixel request -> DAC code pipeline.
// Revision : 1.0  initial release
// ============================================================================
module composite_timing_gen #(
    parameter int DAC_WIDTH         = 4,
    parameter int CLKS_PER_LINE     = 800,
    parameter int HSYNC_CLKS        = 59,
    parameter int BACK_PORCH        = 72,
    parameter int ACTIVE_CLKS       = 640,
    parameter int LINES_PER_FIELD   = 262,
    parameter int VSYNC_START       = 0,
    parameter int VSYNC_LINES       = 3,
    parameter int ACTIVE_LINE_START = 20,
    parameter int ACTIVE_LINES      = 240,
    parameter int BLANK_LEVEL       = 4,
    parameter int BLACK_LEVEL       = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            en,
    input  logic                            interlace,
    input  logic [DAC_WIDTH-1:0]            luma,
    output logic                            pixel_req,
    output logic [$clog2(ACTIVE_CLKS)-1:0]  pixel_x,
    output logic [$clog2(ACTIVE_LINES)-1:0] pixel_y,
    output logic                            field,
    output logic [DAC_WIDTH-1:0]            composite,
    output logic                            hsync,
    output logic                            vsync
);

    localparam int c_HW = $clog2(CLKS_PER_LINE);
    localparam int c_VW = $clog2(LINES_PER_FIELD + 1);
    localparam int c_XW = $clog2(ACTIVE_CLKS);
    localparam int c_YW = $clog2(ACTIVE_LINES);

    // Window bounds are compared as 32-bit offsets so that "lo <= x < lo+n"
    // becomes a single unsigned "(x - lo) < n" with no constant compares.
    localparam logic [31:0] c_HSYNC_END = 32'(HSYNC_CLKS);
    localparam logic [31:0] c_SERR_END  = 32'(CLKS_PER_LINE - HSYNC_CLKS);
    localparam logic [31:0] c_ACT_H0    = 32'(HSYNC_CLKS + BACK_PORCH);
    localparam logic [31:0] c_ACT_W     = 32'(ACTIVE_CLKS);
    localparam logic [31:0] c_VS_V0     = 32'(VSYNC_START);
    localparam logic [31:0] c_VS_N      = 32'(VSYNC_LINES);
    localparam logic [31:0] c_ACT_V0    = 32'(ACTIVE_LINE_START);
    localparam logic [31:0] c_ACT_N     = 32'(ACTIVE_LINES);

    localparam logic [c_HW-1:0]      c_H_LAST  = c_HW'(CLKS_PER_LINE - 1);
    localparam logic [c_VW-1:0]      c_V_LAST0 = c_VW'(LINES_PER_FIELD - 1);
    localparam logic [DAC_WIDTH-1:0] c_BLANK   = DAC_WIDTH'(BLANK_LEVEL);
    localparam logic [DAC_WIDTH-1:0] c_BLACK   = DAC_WIDTH'(BLACK_LEVEL);
    localparam logic [DAC_WIDTH-1:0] c_SYNC    = '0;

    // Decode of the raster origin (h=0,v=0), preloaded at reset so the very
    // first enabled cycle already carries its sync classification.
    localparam logic c_SYNC_AT_ORIGIN = (HSYNC_CLKS > 0);
    localparam logic c_VS_AT_ORIGIN   = (VSYNC_START == 0) && (VSYNC_LINES > 0);

    logic [c_HW-1:0] r_h, w_h_next;
    logic [c_VW-1:0] r_v, w_v_next, w_v_last;
    logic            r_field, w_field_next;
    logic            r_il;
    logic            w_h_wrap, w_v_wrap;

    logic [31:0]     w_px32, w_py32;
    logic            w_vs_line, w_act_line, w_in_win, w_sync;

    logic            r_sync0, r_vs0;
    logic            r_s1_valid, r_s1_req, r_s1_sync, r_s1_vs;

    assign field = r_field;

    // Next raster position; a low enable parks the raster at the field origin
    always_comb begin
        w_v_last     = c_V_LAST0 + c_VW'(r_il & r_field);
        w_h_wrap     = (r_h == c_H_LAST);
        w_v_wrap     = w_h_wrap && (r_v == w_v_last);
        w_h_next     = '0;
        w_v_next     = '0;
        w_field_next = 1'b0;
        if (en) begin
            w_h_next     = w_h_wrap ? '0 : r_h + c_HW'(1);
            w_v_next     = w_h_wrap ? (w_v_wrap ? '0 : r_v + c_VW'(1)) : r_v;
            w_field_next = w_v_wrap ? (interlace & ~r_field) : r_field;
        end
    end

    // Classify the next position: line class, sync region and pixel window
    always_comb begin
        w_px32     = 32'(w_h_next) - c_ACT_H0;
        w_py32     = 32'(w_v_next) - c_ACT_V0;
        w_vs_line  = (32'(w_v_next) - c_VS_V0) < c_VS_N;
        w_act_line = w_py32 < c_ACT_N;
        w_in_win   = w_act_line && (w_px32 < c_ACT_W);
        w_sync     = w_vs_line ? (32'(w_h_next) < c_SERR_END)
                               : (32'(w_h_next) < c_HSYNC_END);
    end

    // Raster counters; interlace mode is captured only at field boundaries
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h     <= '0;
            r_v     <= '0;
            r_field <= 1'b0;
            r_il    <= 1'b0;
        end else begin
            r_h     <= w_h_next;
            r_v     <= w_v_next;
            r_field <= w_field_next;
            if (!en || w_v_wrap) begin
                r_il <= interlace;
            end
        end
    end

    // Request stage: outputs describe the position the counters hold this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_req <= 1'b0;
            pixel_x   <= '0;
            pixel_y   <= '0;
            r_sync0   <= c_SYNC_AT_ORIGIN;
            r_vs0     <= c_VS_AT_ORIGIN;
        end else begin
            pixel_req <= w_in_win;
            pixel_x   <= w_in_win ? w_px32[c_XW-1:0] : '0;
            pixel_y   <= w_in_win ? w_py32[c_YW-1:0] : '0;
            r_sync0   <= w_sync;
            r_vs0     <= w_vs_line;
        end
    end

    // Luma stage: carry the classification one cycle while the pixel arrives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_req   <= 1'b0;
            r_s1_sync  <= 1'b0;
            r_s1_vs    <= 1'b0;
        end else begin
            r_s1_valid <= en;
            r_s1_req   <= pixel_req;
            r_s1_sync  <= r_sync0;
            r_s1_vs    <= r_vs0;
        end
    end

    // DAC stage: sync, clamped luma or blanking; idle pipeline shows blanking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            composite <= c_BLANK;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
        end else if (en && r_s1_valid) begin
            if (r_s1_req) begin
                composite <= (luma < c_BLACK) ? c_BLACK : luma;
            end else if (r_s1_sync) begin
                composite <= c_SYNC;
            end else begin
                composite <= c_BLANK;
            end
            hsync <= r_s1_sync;
            vsync <= r_s1_vs;
        end else begin
            composite <= c_BLANK;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
        end
    end

endmodule
`default_nettype wire
